// File: rtl/cu_decode_mem_ctrl.sv
// ID-stage control decoder with NOP mux and EX/MEM control register
// for the 5-stage ARM-subset pipeline.
module cu_decode_mem_ctrl (
    input  logic        clk,
    input  logic        R,
    input  logic [31:0] instruction,
    input  logic        S,
    output logic [3:0]  ID_opcode,
    output logic        ID_AM,
    output logic        ID_S_enable,
    output logic        ID_load_instr,
    output logic        ID_RF_enable,
    output logic        ID_Size_enable,
    output logic        ID_RW_enable,
    output logic        ID_Enable_signal,
    output logic        ID_BL_instr,
    output logic        ID_B_instr,
    input  logic        in_EX_load_instr,
    input  logic        in_EX_RF_enable,
    input  logic        in_EX_Size_enable,
    input  logic        in_EX_RW_enable,
    input  logic        in_EX_Enable_signal,
    output logic        MEM_load_instr,
    output logic        MEM_RF_enable,
    output logic        MEM_Size_enable,
    output logic        MEM_RW_enable,
    output logic        MEM_Enable_signal
);

    typedef struct packed {
        logic [3:0] opcode;
        logic       am;
        logic       s_en;
        logic       load;
        logic       rf;
        logic       size;
        logic       rw;
        logic       en;
        logic       bl;
        logic       b;
    } ctrl_t;

    ctrl_t dec;
    ctrl_t id;

    logic is_nop;
    logic is_dp;
    logic is_ls;
    logic is_br;

    assign is_nop = (instruction == 32'h0);
    assign is_dp  = !is_nop && (instruction[27:26] == 2'b00);
    assign is_ls  = !is_nop && (instruction[27:26] == 2'b01);
    assign is_br  = !is_nop && (instruction[27:25] == 3'b101);

    always_comb begin
        dec = '0;
        unique case (1'b1)
            is_dp: begin
                dec.opcode = instruction[24:21];
                dec.s_en   = instruction[20];
                dec.am     = instruction[25];
                // compare/test ops only set flags
                dec.rf     = (instruction[24:23] != 2'b10);
            end
            is_ls: begin
                dec.load   = instruction[20];
                dec.rf     = instruction[20];
                dec.en     = 1'b1;
                dec.rw     = ~instruction[20];
                dec.size   = instruction[22];
                dec.am     = ~instruction[25];
                dec.opcode = instruction[23] ? 4'b0100 : 4'b0010;
            end
            is_br: begin
                dec.b      = ~instruction[24];
                dec.bl     = instruction[24];
                dec.rf     = instruction[24];
                dec.opcode = 4'b0100;
            end
            default: dec = '0;
        endcase
    end

    assign id = S ? '0 : dec;

    assign ID_opcode        = id.opcode;
    assign ID_AM            = id.am;
    assign ID_S_enable      = id.s_en;
    assign ID_load_instr    = id.load;
    assign ID_RF_enable     = id.rf;
    assign ID_Size_enable   = id.size;
    assign ID_RW_enable     = id.rw;
    assign ID_Enable_signal = id.en;
    assign ID_BL_instr      = id.bl;
    assign ID_B_instr       = id.b;

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            MEM_load_instr    <= 1'b0;
            MEM_RF_enable     <= 1'b0;
            MEM_Size_enable   <= 1'b0;
            MEM_RW_enable     <= 1'b0;
            MEM_Enable_signal <= 1'b0;
        end else begin
            MEM_load_instr    <= in_EX_load_instr;
            MEM_RF_enable     <= in_EX_RF_enable;
            MEM_Size_enable   <= in_EX_Size_enable;
            MEM_RW_enable     <= in_EX_RW_enable;
            MEM_Enable_signal <= in_EX_Enable_signal;
        end
    end

endmodule

// File: tb/tb_cu_decode_mem_ctrl.sv
// Scoreboard bench for cu_decode_mem_ctrl: ID decode table,
// NOP mux, and EX/MEM register timing and async reset.
module tb_cu_decode_mem_ctrl;

    logic        clk = 1'b0;
    logic        R;
    logic [31:0] instruction;
    logic        S;
    logic [3:0]  ID_opcode;
    logic        ID_AM, ID_S_enable, ID_load_instr, ID_RF_enable;
    logic        ID_Size_enable, ID_RW_enable, ID_Enable_signal;
    logic        ID_BL_instr, ID_B_instr;
    logic        in_EX_load_instr, in_EX_RF_enable, in_EX_Size_enable;
    logic        in_EX_RW_enable, in_EX_Enable_signal;
    logic        MEM_load_instr, MEM_RF_enable, MEM_Size_enable;
    logic        MEM_RW_enable, MEM_Enable_signal;

    int errors = 0;
    int checks = 0;

    logic [12:0] id_q[$];
    logic [4:0]  mem_q[$];

    cu_decode_mem_ctrl dut (
        .clk                 (clk),
        .R                   (R),
        .instruction         (instruction),
        .S                   (S),
        .ID_opcode           (ID_opcode),
        .ID_AM               (ID_AM),
        .ID_S_enable         (ID_S_enable),
        .ID_load_instr       (ID_load_instr),
        .ID_RF_enable        (ID_RF_enable),
        .ID_Size_enable      (ID_Size_enable),
        .ID_RW_enable        (ID_RW_enable),
        .ID_Enable_signal    (ID_Enable_signal),
        .ID_BL_instr         (ID_BL_instr),
        .ID_B_instr          (ID_B_instr),
        .in_EX_load_instr    (in_EX_load_instr),
        .in_EX_RF_enable     (in_EX_RF_enable),
        .in_EX_Size_enable   (in_EX_Size_enable),
        .in_EX_RW_enable     (in_EX_RW_enable),
        .in_EX_Enable_signal (in_EX_Enable_signal),
        .MEM_load_instr      (MEM_load_instr),
        .MEM_RF_enable       (MEM_RF_enable),
        .MEM_Size_enable     (MEM_Size_enable),
        .MEM_RW_enable       (MEM_RW_enable),
        .MEM_Enable_signal   (MEM_Enable_signal)
    );

    always #5 clk = ~clk;

    // {opcode, AM, S, load, RF, Size, RW, En, BL, B}
    logic [12:0] id_obs;
    logic [4:0]  mem_obs;
    assign id_obs = {ID_opcode, ID_AM, ID_S_enable, ID_load_instr,
                     ID_RF_enable, ID_Size_enable, ID_RW_enable,
                     ID_Enable_signal, ID_BL_instr, ID_B_instr};
    // {load, RF, Size, RW, En}
    assign mem_obs = {MEM_load_instr, MEM_RF_enable, MEM_Size_enable,
                      MEM_RW_enable, MEM_Enable_signal};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive_ex(input logic [4:0] v);
        {in_EX_load_instr, in_EX_RF_enable, in_EX_Size_enable,
         in_EX_RW_enable, in_EX_Enable_signal} = v;
    endtask

    task automatic apply_id(input string tag, input logic [31:0] ins,
                            input logic s, input logic [12:0] exp);
        instruction = ins;
        S = s;
        id_q.push_back(exp);
        #1;
        if (id_q.size() == 0) chk({tag, "_empty"}, 32'd1, 32'd0);
        else chk(tag, {19'd0, id_obs}, {19'd0, id_q.pop_front()});
    endtask

    // one EX/MEM transaction: drive at negedge, compare after posedge
    task automatic mem_txn(input string tag, input logic [4:0] v,
                           input logic [4:0] prev);
        @(negedge clk);
        drive_ex(v);
        mem_q.push_back(v);
        #1;
        chk({tag, "_hold"}, {27'd0, mem_obs}, {27'd0, prev});
        @(posedge clk);
        #1;
        if (mem_q.size() == 0) chk({tag, "_empty"}, 32'd1, 32'd0);
        else chk(tag, {27'd0, mem_obs}, {27'd0, mem_q.pop_front()});
    endtask

    typedef struct {
        string       tag;
        logic [31:0] ins;
        logic        s;
        logic [12:0] exp;
    } id_vec_t;

    id_vec_t tbl[$];

    initial begin
        logic [4:0] prev;
        logic [4:0] v;

        R = 1'b1;
        S = 1'b0;
        instruction = 32'h0;
        drive_ex(5'b0);

        // reset behaviour
        @(negedge clk);
        drive_ex(5'b11111);
        @(posedge clk);
        #1;
        chk("mem_pre_rst", {27'd0, mem_obs}, 32'h1f);
        #2;
        R = 1'b0;
        #1;
        chk("mem_async_rst", {27'd0, mem_obs}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("mem_rst_hold", {27'd0, mem_obs}, 32'h0);
        apply_id("id_in_rst", 32'hE5921004, 1'b0, 13'b0100_1_0_1_1_0_0_1_0_0);
        @(negedge clk);
        R = 1'b1;
        #1;
        chk("mem_rst_rel", {27'd0, mem_obs}, 32'h0);
        @(posedge clk);
        #1;
        chk("mem_after_rel", {27'd0, mem_obs}, 32'h1f);

        // decode table
        tbl.push_back('{"adds_imm", 32'hE2921005, 1'b0, 13'b0100_1_1_0_1_0_0_0_0_0});
        tbl.push_back('{"cmp",      32'hE3510000, 1'b0, 13'b1010_1_1_0_0_0_0_0_0_0});
        tbl.push_back('{"tst",      32'hE1100000, 1'b0, 13'b1000_0_1_0_0_0_0_0_0_0});
        tbl.push_back('{"mov_reg",  32'hE1A00001, 1'b0, 13'b1101_0_0_0_1_0_0_0_0_0});
        tbl.push_back('{"and_cond", 32'hE0000000, 1'b0, 13'b0000_0_0_0_1_0_0_0_0_0});
        tbl.push_back('{"ldr_imm",  32'hE5921004, 1'b0, 13'b0100_1_0_1_1_0_0_1_0_0});
        tbl.push_back('{"strb_imm", 32'hE5421004, 1'b0, 13'b0010_1_0_0_0_1_1_1_0_0});
        tbl.push_back('{"ldrb_reg", 32'hE7D21000, 1'b0, 13'b0100_0_0_1_1_1_0_1_0_0});
        tbl.push_back('{"bl",       32'hEB000004, 1'b0, 13'b0100_0_0_0_1_0_0_0_1_0});
        tbl.push_back('{"b",        32'hEA000004, 1'b0, 13'b0100_0_0_0_0_0_0_0_0_1});
        tbl.push_back('{"nop_zero", 32'h00000000, 1'b0, 13'b0});
        tbl.push_back('{"cls100",   32'hE8000000, 1'b0, 13'b0});
        tbl.push_back('{"cls110",   32'hEC000000, 1'b0, 13'b0});
        tbl.push_back('{"cls111",   32'hEF000000, 1'b0, 13'b0});
        tbl.push_back('{"s_ldr",    32'hE5921004, 1'b1, 13'b0});
        tbl.push_back('{"s_bl",     32'hEB000004, 1'b1, 13'b0});
        tbl.push_back('{"s_off",    32'hE5921004, 1'b0, 13'b0100_1_0_1_1_0_0_1_0_0});
        foreach (tbl[i]) apply_id(tbl[i].tag, tbl[i].ins, tbl[i].s, tbl[i].exp);

        // EX/MEM latency and hold
        prev = 5'b11111;
        mem_txn("mem_11011", 5'b11011, prev);
        prev = 5'b11011;

        @(negedge clk);
        drive_ex(5'b00100);
        #1;
        chk("mem_mid_hold1", {27'd0, mem_obs}, {27'd0, prev});
        #2;
        drive_ex(5'b01010);
        mem_q.push_back(5'b01010);
        #1;
        chk("mem_mid_hold2", {27'd0, mem_obs}, {27'd0, prev});
        @(posedge clk);
        #1;
        chk("mem_mid_cap", {27'd0, mem_obs}, {27'd0, mem_q.pop_front()});
        prev = 5'b01010;

        for (int i = 0; i < 8; i++) begin
            v = 5'($urandom_range(0, 31));
            mem_txn("mem_rand", v, prev);
            prev = v;
        end

        if (id_q.size() != 0 || mem_q.size() != 0)
            chk("sb_drain", 32'(id_q.size() + mem_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
